gate_row_draw: RTL and testbench
================================

GATE_ROW_DRAW -- requirements
Module: gate_row_draw

Interface
REQ-001 Parameter N_GATES, default 4, SHALL be the number of gates drawn in one horizontal row (legal 1..16).
REQ-002 Parameter OBJ_W, default 20, SHALL be the gate width in pixels.
REQ-003 Parameter OBJ_H, default 20, SHALL be the gate height in pixels.
REQ-004 Parameter PITCH, default 40, SHALL be the X distance between left edges of adjacent gates (PITCH >= OBJ_W).
REQ-005 Parameters START_X, default 100, and START_Y, default 200, SHALL be the top-left pixel of gate 0.
REQ-006 Parameters GATE_COLOR, default 8'h3E, and EDGE_COLOR, default 8'hFF, SHALL be the body and top/bottom-row colours.
REQ-007 Parameter HOLD_FRAMES, default 30, SHALL be the number of frames a gate stays fully open.
REQ-008 CLK  input  1  system clock; all logic on rising edge.
REQ-009 RESET  input  1  synchronous, active-high reset.
REQ-010 oCoord_X  input  11  current pixel X.
REQ-011 oCoord_Y  input  11  current pixel Y.
REQ-012 startOfFrame  input  1  one-cycle pulse per frame; the animation time base.
REQ-013 enable  input  1  permits starting a new open/close cycle.
REQ-014 random  input  4  random value used to select the gate to open.
REQ-015 gate_draw_req  output  1  pixel belongs to a visible gate pixel.
REQ-016 mVGA_RGB  output  8  pixel colour, valid when gate_draw_req=1.
REQ-017 open_idx  output  4  index of the gate being animated.
REQ-018 gate_passable  output  N_GATES  one-hot; bit k=1 only while gate k is in OPEN.

Function
REQ-019 Gate k rectangle SHALL be X in [START_X+k*PITCH, START_X+k*PITCH+OBJ_W), Y in [START_Y, START_Y+OBJ_H); comparisons unsigned, at least 12 bits wide, so no wrap.
REQ-020 FSM states SHALL be IDLE, OPENING, OPEN, CLOSING; a level counter (0..OBJ_H) holds the number of hidden top rows of the selected gate.
REQ-021 IDLE: on startOfFrame with enable=1, SHALL latch open_idx = random mod N_GATES, set level=0, go OPENING; with enable=0, SHALL stay in IDLE.
REQ-022 OPENING: each startOfFrame SHALL increment level; when level reaches OBJ_H, SHALL go OPEN and clear the hold counter.
REQ-023 OPEN: each startOfFrame SHALL increment the hold counter; at HOLD_FRAMES SHALL go CLOSING.
REQ-024 CLOSING: each startOfFrame SHALL decrement level; on reaching 0 SHALL go IDLE.
REQ-025 enable deasserting outside IDLE SHALL NOT abort the cycle; it only blocks the next start.
REQ-026 open_idx SHALL remain constant from leaving IDLE until re-entering IDLE.
REQ-027 A pixel inside gate k at row r = oCoord_Y-START_Y SHALL be visible unless k=open_idx, the state is not IDLE, and r < level.
REQ-028 Visible rows r=0 and r=OBJ_H-1 SHALL use EDGE_COLOR; all other visible rows SHALL use GATE_COLOR.
REQ-029 gate_draw_req and mVGA_RGB SHALL be registered with exactly 1 cycle latency from the oCoord inputs; mVGA_RGB SHALL be 8'h00 when gate_draw_req=0.
REQ-030 Level and state updates on startOfFrame SHALL take effect for pixels sampled on the following cycle onward; there SHALL be no mid-pixel glitching within a cycle.
REQ-031 gate_passable SHALL be registered and SHALL be all-zero in every state but OPEN.

Reset
REQ-032 While RESET=1 at a clock edge: state=IDLE, level=0, hold counter=0, open_idx=0, gate_draw_req=0, mVGA_RGB=8'h00, gate_passable=0; reset mid-animation SHALL abandon the cycle immediately.

Verification
REQ-033 Defaults, IDLE, pixel (100,200) -> next cycle gate_draw_req=1, mVGA_RGB=8'hFF; pixel (110,205) -> 1, 8'h3E; pixel (120,205) and (99,205) -> 0, 8'h00.
REQ-034 enable=1, random=6, startOfFrame -> open_idx=2; after 5 more frames, pixel (185,204) -> req=0, (185,205) -> req=1, 8'h3E; gate 1 pixel (145,204) -> req=1.
REQ-035 Full cycle: count frames -> 1 start frame + 20 OPENING frames, gate_passable=4'b0100 for 30 frames, 20 CLOSING frames, then IDLE with gate 2 fully drawn.
REQ-036 enable dropped during OPEN -> cycle completes to IDLE; no new cycle starts while enable=0.
REQ-037 RESET pulse during OPENING (level=10) -> next cycle all outputs at reset values, gate 2 fully drawn again.
REQ-038 N_GATES=3, random=15 -> open_idx=0; pixel X=START_X+3*PITCH -> req=0.

Source files
------------

// File: rtl/gate_row_draw.sv
// gate_row_draw
//   Draws a horizontal row of N_GATES rectangular gates and animates one of
//   them at a time. The selected gate "opens" by hiding its top rows one per
//   frame, stays open for HOLD_FRAMES frames, then closes again row by row.
//
// Ports
//   CLK            system clock, rising edge
//   RESET          synchronous, active-high reset
//   oCoord_X/Y     current pixel coordinate (11 bit)
//   startOfFrame   one-cycle pulse per frame, the animation time base
//   enable         permits starting a new open/close cycle
//   random         selects the gate to open (taken mod N_GATES)
//   gate_draw_req  registered: the previous cycle's pixel is a visible gate pixel
//   mVGA_RGB       registered pixel colour, 8'h00 when gate_draw_req=0
//   open_idx       index of the gate being animated
//   gate_passable  registered one-hot of open_idx, only while fully open
module gate_row_draw #(
  parameter int          N_GATES     = 4,
  parameter int          OBJ_W       = 20,
  parameter int          OBJ_H       = 20,
  parameter int          PITCH       = 40,
  parameter int          START_X     = 100,
  parameter int          START_Y     = 200,
  parameter logic [7:0]  GATE_COLOR  = 8'h3E,
  parameter logic [7:0]  EDGE_COLOR  = 8'hFF,
  parameter int          HOLD_FRAMES = 30
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic [10:0]        oCoord_X,
  input  logic [10:0]        oCoord_Y,
  input  logic               startOfFrame,
  input  logic               enable,
  input  logic [3:0]         random,
  output logic               gate_draw_req,
  output logic [7:0]         mVGA_RGB,
  output logic [3:0]         open_idx,
  output logic [N_GATES-1:0] gate_passable
);

  localparam int LW = (OBJ_H < 1) ? 1 : $clog2(OBJ_H + 1);
  localparam int HW = (HOLD_FRAMES < 1) ? 1 : $clog2(HOLD_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, OPENING, OPEN, CLOSING} state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   level, level_nx;
  logic [HW-1:0]   hold, hold_nx;
  logic [3:0]      idx_nx;
  logic [3:0]      rnd_idx;
  logic [N_GATES-1:0] pass_nx;

  // random mod N_GATES; a full 16-gate row uses the value directly so the
  // 4-bit modulus constant never collapses to zero.
  generate
    if (N_GATES >= 16) begin : g_idx_full
      assign rnd_idx = random;
    end else begin : g_idx_mod
      assign rnd_idx = random % 4'(N_GATES);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Animation FSM: all changes happen only on startOfFrame.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nx = state;
    level_nx = level;
    hold_nx  = hold;
    idx_nx   = open_idx;
    case (state)
      IDLE: begin
        if (startOfFrame && enable) begin
          state_nx = OPENING;
          level_nx = '0;
          hold_nx  = '0;
          idx_nx   = rnd_idx;
        end
      end
      OPENING: begin
        if (startOfFrame) begin
          level_nx = level + LW'(1);
          if (level_nx == LW'(OBJ_H)) begin
            state_nx = OPEN;
            hold_nx  = '0;
          end
        end
      end
      OPEN: begin
        if (startOfFrame) begin
          hold_nx = hold + HW'(1);
          if (hold_nx == HW'(HOLD_FRAMES)) state_nx = CLOSING;
        end
      end
      CLOSING: begin
        if (startOfFrame) begin
          level_nx = level - LW'(1);
          if (level_nx == '0) state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Passable is built from the next state so the registered copy lines up
  // with the state register exactly.
  always_comb begin
    pass_nx = '0;
    if (state_nx == OPEN) begin
      for (int k = 0; k < N_GATES; k++)
        if (idx_nx == 4'(k)) pass_nx[k] = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Pixel path: 32-bit unsigned compares so no coordinate can wrap.
  // ---------------------------------------------------------------------------
  logic [31:0]        xw, yw, row_w;
  logic               in_y;
  logic [N_GATES-1:0] hit, hit_sel;
  logic               any_hit, sel_hidden, vis;
  logic [7:0]         pix_color;

  assign xw    = {21'd0, oCoord_X};
  assign yw    = {21'd0, oCoord_Y};
  assign in_y  = (yw >= 32'(START_Y)) && (yw < 32'(START_Y + OBJ_H));
  assign row_w = yw - 32'(START_Y);

  generate
    for (genvar k = 0; k < N_GATES; k++) begin : g_gate
      localparam int X0 = START_X + k * PITCH;
      assign hit[k]     = in_y && (xw >= 32'(X0)) && (xw < 32'(X0 + OBJ_W));
      assign hit_sel[k] = hit[k] && (open_idx == 4'(k));
    end
  endgenerate

  assign any_hit    = |hit;
  // Top rows of the animated gate are hidden while any cycle is in flight.
  assign sel_hidden = (|hit_sel) && (state != IDLE) && (row_w < 32'(level));
  assign vis        = any_hit && !sel_hidden;
  assign pix_color  = ((row_w == 32'd0) || (row_w == 32'(OBJ_H - 1))) ? EDGE_COLOR
                                                                       : GATE_COLOR;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state         <= IDLE;
      level         <= '0;
      hold          <= '0;
      open_idx      <= '0;
      gate_passable <= '0;
      gate_draw_req <= 1'b0;
      mVGA_RGB      <= 8'h00;
    end else begin
      state         <= state_nx;
      level         <= level_nx;
      hold          <= hold_nx;
      open_idx      <= idx_nx;
      gate_passable <= pass_nx;
      gate_draw_req <= vis;
      mVGA_RGB      <= vis ? pix_color : 8'h00;
    end
  end

endmodule

// File: tb/tb_gate_row_draw.sv
module tb_gate_row_draw;

  localparam int NG = 4, W = 20, H = 20, P = 40, SX = 100, SY = 200, HF = 30;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic [10:0] px = '0, py = '0;
  logic        sof = 1'b0, en = 1'b0;
  logic [3:0]  rnd = '0;

  logic        req;
  logic [7:0]  rgb;
  logic [3:0]  idx;
  logic [3:0]  pass;
  logic        req3;
  logic [7:0]  rgb3;
  logic [3:0]  idx3;
  logic [2:0]  pass3;

  int checks = 0, failures = 0;

  // Reference model: time since the start frame describes the whole cycle.
  bit         m_active = 0;
  int         m_f = 0;
  int         m_idx = 0;
  logic       exp_req;
  logic [7:0] exp_rgb;

  always #5 CLK = ~CLK;

  gate_row_draw dut (
    .CLK(CLK), .RESET(RESET), .oCoord_X(px), .oCoord_Y(py),
    .startOfFrame(sof), .enable(en), .random(rnd),
    .gate_draw_req(req), .mVGA_RGB(rgb), .open_idx(idx), .gate_passable(pass)
  );

  gate_row_draw #(.N_GATES(3)) dut3 (
    .CLK(CLK), .RESET(RESET), .oCoord_X(px), .oCoord_Y(py),
    .startOfFrame(sof), .enable(en), .random(rnd),
    .gate_draw_req(req3), .mVGA_RGB(rgb3), .open_idx(idx3), .gate_passable(pass3)
  );

  function automatic int m_hidden();
    if (!m_active)           return 0;
    if (m_f <= H)            return m_f;
    if (m_f < H + HF)        return H;
    return 2 * H + HF - m_f;
  endfunction

  function automatic logic [3:0] m_pass();
    if (m_active && m_f >= H && m_f < H + HF) return 4'(1 << m_idx);
    return 4'b0000;
  endfunction

  function automatic void model_pixel(input int x, input int y,
                                      output logic r, output logic [7:0] c);
    int row;
    r = 1'b0;
    c = 8'h00;
    row = y - SY;
    for (int k = 0; k < NG; k++) begin
      if (x >= SX + k * P && x < SX + k * P + W && y >= SY && y < SY + H) begin
        if (!(m_active && k == m_idx && row < m_hidden())) begin
          r = 1'b1;
          c = (row == 0 || row == H - 1) ? 8'hFF : 8'h3E;
        end
      end
    end
  endfunction

  // One clock: drive inputs, advance the model, leave outputs settled.
  task automatic tick(input logic s, input int x, input int y);
    @(negedge CLK);
    sof = s;
    px  = 11'(x);
    py  = 11'(y);
    model_pixel(x, y, exp_req, exp_rgb);
    @(posedge CLK);
    if (RESET) begin
      m_active = 0; m_f = 0; m_idx = 0;
      exp_req = 1'b0; exp_rgb = 8'h00;
    end else if (s) begin
      if (!m_active) begin
        if (en) begin m_active = 1; m_f = 0; m_idx = int'(rnd) % NG; end
      end else begin
        m_f++;
        if (m_f == 2 * H + HF) m_active = 0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; en = 1'b0;
    tick(0, 100, 200);
    tick(0, 100, 200);
    checks++; if (req !== 1'b0)     begin failures++; $display("FAIL reset_req got=%0h exp=0", req); end
    checks++; if (rgb !== 8'h00)    begin failures++; $display("FAIL reset_rgb got=%0h exp=0", rgb); end
    checks++; if (idx !== 4'd0)     begin failures++; $display("FAIL reset_idx got=%0h exp=0", idx); end
    checks++; if (pass !== 4'b0000) begin failures++; $display("FAIL reset_pass got=%0h exp=0", pass); end
    RESET = 1'b0;
  endtask

  task automatic test_static_pixels();
    int         xs[4] = '{100, 110, 120, 99};
    int         ys[4] = '{200, 205, 205, 205};
    logic       er[4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ec[4] = '{8'hFF, 8'h3E, 8'h00, 8'h00};
    for (int i = 0; i < 4; i++) begin
      tick(0, xs[i], ys[i]);
      checks++;
      if (req !== er[i] || rgb !== ec[i]) begin
        failures++;
        $display("FAIL static_pix(%0d,%0d) got=%0h/%0h exp=%0h/%0h", xs[i], ys[i], req, rgb, er[i], ec[i]);
      end
    end
    for (int i = 0; i < 30; i++) begin
      tick(0, $urandom_range(90, 280), $urandom_range(195, 225));
      checks++;
      if (req !== exp_req || rgb !== exp_rgb) begin
        failures++;
        $display("FAIL static_rand(%0d,%0d) got=%0h/%0h exp=%0h/%0h", px, py, req, rgb, exp_req, exp_rgb);
      end
    end
  endtask

  task automatic test_open_cycle();
    int n, cnt;
    en = 1'b1; rnd = 4'd6;
    tick(1, 185, 204);
    en = 1'b0;
    checks++; if (idx !== 4'd2) begin failures++; $display("FAIL start_idx got=%0d exp=2", idx); end
    repeat (5) tick(1, 185, 204);
    tick(0, 185, 204);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL hidden_row4 got=%0h exp=0", req); end
    tick(0, 185, 205);
    checks++; if (req !== 1'b1 || rgb !== 8'h3E) begin failures++; $display("FAIL row5 got=%0h/%0h exp=1/3e", req, rgb); end
    tick(0, 145, 204);
    checks++; if (req !== 1'b1) begin failures++; $display("FAIL gate1_row4 got=%0h exp=1", req); end
    // Opening: frames counted from the start frame until passable appears.
    n = 5;
    while (n < 100) begin
      tick(1, 185, 210);
      n++;
      if (pass === 4'b0100) break;
    end
    checks++; if (n !== H) begin failures++; $display("FAIL opening_frames got=%0d exp=%0d", n, H); end
    cnt = 0;
    while (cnt < 100) begin
      tick(1, 185, 210);
      cnt++;
      if (pass !== 4'b0100) break;
    end
    checks++; if (cnt !== HF) begin failures++; $display("FAIL open_frames got=%0d exp=%0d", cnt, HF); end
    checks++; if (pass !== 4'b0000) begin failures++; $display("FAIL closing_pass got=%0h exp=0", pass); end
    cnt = 0;
    while (cnt < 100) begin
      tick(1, 185, 200);
      cnt++;
      tick(0, 185, 200);
      checks++;
      if (req !== exp_req || rgb !== exp_rgb) begin
        failures++;
        $display("FAIL closing_pix got=%0h/%0h exp=%0h/%0h", req, rgb, exp_req, exp_rgb);
      end
      if (req === 1'b1) break;
    end
    checks++; if (cnt !== H) begin failures++; $display("FAIL closing_frames got=%0d exp=%0d", cnt, H); end
    tick(0, 185, 219);
    checks++; if (req !== 1'b1 || rgb !== 8'hFF) begin failures++; $display("FAIL idle_bottom got=%0h/%0h exp=1/ff", req, rgb); end
    checks++; if (idx !== 4'd2) begin failures++; $display("FAIL idle_idx got=%0d exp=2", idx); end
  endtask

  task automatic test_enable_drop();
    int guard;
    en = 1'b1; rnd = 4'd1;
    tick(1, 145, 200);
    repeat (25) tick(1, 145, 200);
    checks++; if (pass !== 4'b0010) begin failures++; $display("FAIL drop_open_pass got=%0h exp=2", pass); end
    en = 1'b0;
    guard = 0;
    while (m_active && guard < 100) begin
      tick(1, $urandom_range(90, 280), $urandom_range(195, 225));
      guard++;
      checks++;
      if (req !== exp_req || rgb !== exp_rgb || pass !== m_pass()) begin
        failures++;
        $display("FAIL drop_run got=%0h/%0h/%0h exp=%0h/%0h/%0h", req, rgb, pass, exp_req, exp_rgb, m_pass());
      end
    end
    checks++; if (guard >= 100) begin failures++; $display("FAIL drop_timeout got=%0d exp<100", guard); end
    repeat (5) begin
      tick(1, 145, 200);
      tick(0, 145, 200);
      checks++;
      if (req !== 1'b1 || rgb !== 8'hFF || pass !== 4'b0000 || idx !== 4'd1) begin
        failures++;
        $display("FAIL no_restart got=%0h/%0h/%0h/%0h exp=1/ff/0/1", req, rgb, pass, idx);
      end
    end
  endtask

  task automatic test_reset_mid();
    en = 1'b1; rnd = 4'd2;
    tick(1, 185, 205);
    en = 1'b0;
    repeat (10) tick(1, 185, 205);
    tick(0, 185, 205);
    checks++; if (req !== 1'b0) begin failures++; $display("FAIL mid_hidden got=%0h exp=0", req); end
    RESET = 1'b1;
    tick(0, 185, 200);
    RESET = 1'b0;
    checks++;
    if (req !== 1'b0 || rgb !== 8'h00 || idx !== 4'd0 || pass !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset got=%0h/%0h/%0h/%0h exp=0/0/0/0", req, rgb, idx, pass);
    end
    tick(0, 185, 200);
    checks++; if (req !== 1'b1 || rgb !== 8'hFF) begin failures++; $display("FAIL after_reset_top got=%0h/%0h exp=1/ff", req, rgb); end
    tick(0, 185, 209);
    checks++; if (req !== 1'b1 || rgb !== 8'h3E) begin failures++; $display("FAIL after_reset_mid got=%0h/%0h exp=1/3e", req, rgb); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 49) == 0) en = ~en;
      rnd   = 4'($urandom_range(0, 15));
      RESET = ($urandom_range(0, 999) == 0);
      tick($urandom_range(0, 2) == 0, $urandom_range(90, 280), $urandom_range(195, 225));
      checks++;
      if (req !== exp_req || rgb !== exp_rgb || idx !== 4'(m_idx) || pass !== m_pass()) begin
        failures++;
        $display("FAIL random[%0d] got=%0h/%0h/%0h/%0h exp=%0h/%0h/%0h/%0h", i,
                 req, rgb, idx, pass, exp_req, exp_rgb, m_idx, m_pass());
      end
    end
    RESET = 1'b0;
  endtask

  task automatic test_n3();
    RESET = 1'b1;
    tick(0, 0, 0);
    RESET = 1'b0;
    en = 1'b1; rnd = 4'd15;
    tick(1, 220, 205);
    en = 1'b0;
    checks++; if (idx3 !== 4'd0) begin failures++; $display("FAIL n3_idx got=%0d exp=0", idx3); end
    checks++; if (idx !== 4'd3)  begin failures++; $display("FAIL n4_idx got=%0d exp=3", idx); end
    tick(0, 220, 205);
    checks++; if (req3 !== 1'b0 || rgb3 !== 8'h00) begin failures++; $display("FAIL n3_beyond got=%0h/%0h exp=0/0", req3, rgb3); end
    checks++; if (req !== 1'b1 || rgb !== 8'h3E)   begin failures++; $display("FAIL n4_gate3 got=%0h/%0h exp=1/3e", req, rgb); end
    tick(0, 199, 205);
    checks++; if (req3 !== 1'b1 || rgb3 !== 8'h3E) begin failures++; $display("FAIL n3_gate2 got=%0h/%0h exp=1/3e", req3, rgb3); end
  endtask

  initial begin
    test_reset();
    test_static_pixels();
    test_open_cycle();
    test_enable_drop();
    test_reset_mid();
    test_random();
    test_n3();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
